// File: rtl/mips_bus_arbiter_if.sv
// rtl/mips_bus_arbiter_if.sv - bus bundle between two CPU masters, the arbiter and the shared slave
// Purpose: carries the m0 (fetch), m1 (data) and s (memory) Avalon-style signal groups.
// Modports:
//   master - the arbiter's view: takes master requests, drives the slave side
//   slave  - the environment's view: drives master requests and the slave response
interface mips_bus_arbiter_if;
    logic [31:0] m0_address;
    logic        m0_read;
    logic        m0_write;
    logic [31:0] m0_writedata;
    logic [3:0]  m0_byteenable;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;

    logic [31:0] m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_writedata;
    logic [3:0]  m1_byteenable;
    logic        m1_waitrequest;
    logic [31:0] m1_readdata;

    logic [31:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_waitrequest;
    logic [31:0] s_readdata;

    modport master (
        input  m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
        output m0_waitrequest, m0_readdata,
        input  m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        output m1_waitrequest, m1_readdata,
        output s_address, s_read, s_write, s_writedata, s_byteenable,
        input  s_waitrequest, s_readdata
    );

    modport slave (
        output m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
        input  m0_waitrequest, m0_readdata,
        output m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        input  m1_waitrequest, m1_readdata,
        input  s_address, s_read, s_write, s_writedata, s_byteenable,
        output s_waitrequest, s_readdata
    );
endinterface

// File: rtl/mips_bus_arbiter.sv
// rtl/mips_bus_arbiter.sv - two-master arbiter for one shared memory slave with stall watchdog
// Purpose: grants one transaction at a time to the fetch master (m0) or data master (m1),
//          muxes the owner onto the slave and holds the other in waitrequest.
// Ports:
//   clk          - clock, rising edge
//   reset        - asynchronous active-high reset
//   bus          - mips_bus_arbiter_if.master (m0_*, m1_*, s_* groups)
//   grant        - one-hot owner {m1,m0}, 2'b00 when idle
//   timeout_err  - sticky, set when the watchdog aborts a transaction
module mips_bus_arbiter #(
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                clk,
    input  logic                reset,
    mips_bus_arbiter_if.master  bus,
    output logic [1:0]          grant,
    output logic                timeout_err
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;   // 0: m0 served last, 1: m1 served last
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            timeout_err_q, timeout_err_d;

    logic            req0, req1;
    logic            own_req;
    logic            own_id;
    logic            wd_hit;

    assign req0 = bus.m0_read | bus.m0_write;
    assign req1 = bus.m1_read | bus.m1_write;

    // Abort cycle: the owner has been stalled TIMEOUT cycles and the slave is still stalling.
    assign wd_hit = (TIMEOUT != 0) && (cnt_q == CNT_LIMIT) && bus.s_waitrequest;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        own_req       = 1'b0;
        own_id        = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req0 && req1) begin
                    state_d = (ROUND_ROBIN && last_grant_q) ? OWN0 : OWN1;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                own_id  = (state_q == OWN1);
                own_req = own_id ? req1 : req0;
                if (!own_req) begin
                    // Owner withdrew: release without touching fairness history.
                    state_d = IDLE;
                end else if (wd_hit) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                    last_grant_d  = own_id;
                end else if (!bus.s_waitrequest) begin
                    state_d      = IDLE;
                    last_grant_d = own_id;
                end else if ((TIMEOUT != 0) && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.s_address      = '0;
        bus.s_read         = 1'b0;
        bus.s_write        = 1'b0;
        bus.s_writedata    = '0;
        bus.s_byteenable   = '0;
        bus.m0_waitrequest = 1'b1;
        bus.m1_waitrequest = 1'b1;
        grant              = 2'b00;
        case (state_q)
            OWN0: begin
                bus.s_address      = bus.m0_address;
                bus.s_read         = bus.m0_read & ~bus.m0_write;   // write wins a read+write
                bus.s_write        = bus.m0_write;
                bus.s_writedata    = bus.m0_writedata;
                bus.s_byteenable   = bus.m0_byteenable;
                bus.m0_waitrequest = bus.s_waitrequest & ~wd_hit;
                grant              = 2'b01;
            end
            OWN1: begin
                bus.s_address      = bus.m1_address;
                bus.s_read         = bus.m1_read & ~bus.m1_write;
                bus.s_write        = bus.m1_write;
                bus.s_writedata    = bus.m1_writedata;
                bus.s_byteenable   = bus.m1_byteenable;
                bus.m1_waitrequest = bus.s_waitrequest & ~wd_hit;
                grant              = 2'b10;
            end
            default: ;
        endcase
    end

    assign bus.m0_readdata = bus.s_readdata;
    assign bus.m1_readdata = bus.s_readdata;
    assign timeout_err     = timeout_err_q;
endmodule
